// File: rtl/fu_matrix_ls_sequencer.sv
// fu_matrix_ls_sequencer: breaks one matrix load/store request into ROWS
// row accesses, handshakes each row with the scratchpad, and then pulses
// mhit back to fu_matrix_ls.
// Optional build macro MLS_SEQ_PERF_EN adds the saturating stall_cycles counter.
module fu_matrix_ls_sequencer #(
    parameter int ROWS     = 4,
    parameter int ADDR_W   = 32,
    parameter int STRIDE_W = 32,
    parameter int RD_W     = 5
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    enable,
    input  logic [1:0]              ls_in,
    input  logic [RD_W-1:0]         rd_in,
    input  logic [ADDR_W-1:0]       address_in,
    input  logic [STRIDE_W-1:0]     stride_in,
    output logic                    busy,
    output logic                    mhit,
    output logic                    mem_ren,
    output logic                    mem_wen,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [RD_W-1:0]         mem_rd,
    output logic [$clog2(ROWS)-1:0] mem_row,
    input  logic                    mem_gnt
`ifdef MLS_SEQ_PERF_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                is_store;
    logic [RD_W-1:0]     rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   stride_q;
    logic [ROW_W-1:0]    row_q;
    logic                accept;
    logic                last_row;

    // Only LOAD (01) and STORE (10) start a request; 00/11 are no-ops.
    assign accept   = enable && (ls_in == 2'b01 || ls_in == 2'b10);
    assign last_row = (row_q == ROW_W'(ROWS - 1));

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; enable is ignored outside IDLE and mem_gnt outside ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (mem_gnt && last_row) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latches and the row/address accumulator; the row address is
    // built by repeated addition of the stride, so no multiplier is needed,
    // and it wraps modulo 2^ADDR_W.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            is_store <= 1'b0;
            rd_q     <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            row_q    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    is_store <= (ls_in == 2'b10);
                    rd_q     <= rd_in;
                    addr_q   <= address_in;
                    stride_q <= ADDR_W'(stride_in);
                    row_q    <= '0;
                end
                ISSUE: if (mem_gnt) begin
                    row_q  <= row_q + ROW_W'(1);
                    addr_q <= addr_q + stride_q;
                end
                default: ;
            endcase
        end
    end

`ifdef MLS_SEQ_PERF_EN
    // Count cycles spent waiting for a grant; saturate and clear only on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            stall_cycles <= '0;
        else if (state == ISSUE && !mem_gnt && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

    // Outputs are decoded from registered state, so the request stays stable until granted.
    assign busy     = (state != IDLE);
    assign mhit     = (state == DONE);
    assign mem_ren  = (state == ISSUE) && !is_store;
    assign mem_wen  = (state == ISSUE) &&  is_store;
    assign mem_addr = addr_q;
    assign mem_rd   = rd_q;
    assign mem_row  = row_q;

endmodule

// File: tb/tb_fu_matrix_ls_sequencer.sv
// Self-checking bench for fu_matrix_ls_sequencer. Expected row addresses come
// from base + row*stride, and grant-wait schedules are computed up front.
module tb_fu_matrix_ls_sequencer;
    localparam int ROWS = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  ls_in = 2'b00;
    logic [4:0]  rd_in = '0;
    logic [31:0] address_in = '0;
    logic [31:0] stride_in = '0;
    logic        busy, mhit, mem_ren, mem_wen;
    logic [31:0] mem_addr;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_row;
    logic        mem_gnt = 1'b0;
`ifdef MLS_SEQ_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;
    longint exp_stall = 0;

    fu_matrix_ls_sequencer #(.ROWS(ROWS), .ADDR_W(32), .STRIDE_W(32), .RD_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .enable(enable), .ls_in(ls_in), .rd_in(rd_in),
        .address_in(address_in), .stride_in(stride_in), .busy(busy), .mhit(mhit),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_row(mem_row), .mem_gnt(mem_gnt)
`ifdef MLS_SEQ_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [41:0] got;
        nRST = 1'b0;
        mem_gnt = 1'b1;
        enable = 1'b1;
        ls_in = 2'b01;
        #3;
        repeat (2) begin
            step();
            got = {busy, mhit, mem_ren, mem_wen, mem_addr, mem_rd, mem_row};
            n_vec++;
            if (got !== 42'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got %h want 0", got);
            end
        end
`ifdef MLS_SEQ_PERF_EN
        n_vec++;
        if (stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stall: got %0d want 0", stall_cycles);
        end
`endif
        exp_stall = 0;
        enable = 1'b0;
        ls_in = 2'b00;
        mem_gnt = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        step();
    endtask

    // Run one request. mode 0: grant at once, 1: two waits per row, 2: random waits.
    // jam keeps enable asserted with random fields while the sequencer is busy.
    task automatic run_req(input string name, input logic [1:0] ls, input logic [4:0] rd,
                           input logic [31:0] base, input logic [31:0] stride,
                           input int mode, input bit jam);
        int waits[ROWS];
        logic [41:0] got, exp;
        logic [31:0] a;
        for (int r = 0; r < ROWS; r++)
            waits[r] = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
        enable = 1'b1;
        ls_in = ls;
        rd_in = rd;
        address_in = base;
        stride_in = stride;
        mem_gnt = 1'b0;
        step();
        for (int r = 0; r < ROWS; r++) begin
            for (int w = 0; w <= waits[r]; w++) begin
                enable = jam;
                if (jam) begin
                    ls_in = 2'($urandom);
                    rd_in = 5'($urandom);
                    address_in = $urandom;
                    stride_in = $urandom;
                end
                a = base + 32'(r) * stride;
                exp = {1'b1, 1'b0, ls == 2'b01, ls == 2'b10, a, rd, 2'(r)};
                got = {busy, mhit, mem_ren, mem_wen, mem_addr, mem_rd, mem_row};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL %s row%0d wait%0d: got %h want %h", name, r, w, got, exp);
                end
                mem_gnt = (w == waits[r]);
                if (w < waits[r] && exp_stall < 64'hFFFF_FFFF) exp_stall++;
                step();
            end
        end
        enable = 1'b0;
        mem_gnt = 1'($urandom);
        got = {busy, mhit, mem_ren, mem_wen, 38'd0};
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 38'd0};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s done: got %h want %h", name, got, exp);
        end
        step();
        mem_gnt = 1'b0;
        got = {busy, mhit, mem_ren, mem_wen, 38'd0};
        n_vec++;
        if (got !== 42'd0) begin
            n_err++;
            $display("FAIL %s idle_after: got %h want 0", name, got);
        end
`ifdef MLS_SEQ_PERF_EN
        n_vec++;
        if (stall_cycles !== 32'(exp_stall)) begin
            n_err++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles, exp_stall);
        end
`endif
    endtask

    task automatic test_load_basic();
        run_req("load_basic", 2'b01, 5'd3, 32'h100, 32'h10, 0, 1'b0);
    endtask

    task automatic test_store_stall();
        run_req("store_stall", 2'b10, 5'd7, 32'h40, 32'h8, 1, 1'b0);
    endtask

    task automatic test_wrap();
        run_req("wrap", 2'b01, 5'd1, 32'hFFFF_FFF0, 32'h10, 0, 1'b0);
        run_req("stride0", 2'b10, 5'd9, 32'h1234_5678, 32'h0, 2, 1'b0);
    endtask

    task automatic test_noop_and_busy_enable();
        logic [3:0] got;
        for (int i = 0; i < 4; i++) begin
            enable = 1'b1;
            ls_in = (i[0]) ? 2'b11 : 2'b00;
            mem_gnt = i[1];
            step();
            got = {busy, mhit, mem_ren, mem_wen};
            n_vec++;
            if (got !== 4'd0) begin
                n_err++;
                $display("FAIL noop_ls%0b: got %b want 0000", ls_in, got);
            end
        end
        enable = 1'b0;
        mem_gnt = 1'b0;
        run_req("busy_jam", 2'b01, 5'd12, 32'h2000, 32'h44, 2, 1'b1);
    endtask

    task automatic test_reset_abort();
        logic [41:0] got;
        enable = 1'b1;
        ls_in = 2'b01;
        rd_in = 5'd5;
        address_in = 32'h800;
        stride_in = 32'h20;
        step();
        enable = 1'b0;
        mem_gnt = 1'b1;
        step();
        step();
        mem_gnt = 1'b0;
        #2 nRST = 1'b0;
        #1;
        got = {busy, mhit, mem_ren, mem_wen, mem_addr, mem_rd, mem_row};
        n_vec++;
        if (got !== 42'd0) begin
            n_err++;
            $display("FAIL abort_immediate: got %h want 0", got);
        end
        exp_stall = 0;
        step();
        got = {busy, mhit, mem_ren, mem_wen, mem_addr, mem_rd, mem_row};
        n_vec++;
        if (got !== 42'd0) begin
            n_err++;
            $display("FAIL abort_held: got %h want 0", got);
        end
        @(negedge CLK);
        nRST = 1'b1;
        step();
        run_req("after_abort", 2'b01, 5'd2, 32'h3000, 32'h4, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_req("random", ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 5'($urandom),
                    $urandom, $urandom, 2, 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_stall();
        test_wrap();
        test_noop_and_busy_enable();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
